// File: rtl/dual_prio_grant_seq.sv
// dual_prio_grant_seq: request collector and grant sequencer around an external
// dual priority encoder. Request pulses accumulate in pend, the encoder's
// first/second codes come back and are issued as grants over valid/ready, and
// every accepted grant clears its pending bit.
// Optional feature: define DUAL_PRIO_PAIR_BURST_EN to grant the second code
// back-to-back with the first (two grants per encode). Without it every burst is
// a single grant followed by an IDLE cycle and a fresh encode.
module dual_prio_grant_seq #(
    parameter int N      = 12,
    parameter int CODE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req_in,
    input  logic              flush,
    output logic [N-1:0]      pend,
    input  logic [CODE_W-1:0] first,
    input  logic [CODE_W-1:0] second,
    output logic              gnt_valid,
    input  logic              gnt_ready,
    output logic [CODE_W-1:0] gnt_code,
    output logic              busy,
    output logic              enc_err
);

`ifdef DUAL_PRIO_PAIR_BURST_EN
    localparam bit PAIR_EN = 1'b1;
`else
    localparam bit PAIR_EN = 1'b0;
`endif

    localparam logic [CODE_W-1:0] N_CODE = CODE_W'(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } state_t;

    state_t              state_q;
    logic [N-1:0]        pend_q;
    logic [N-1:0]        pend_d;
    logic [CODE_W-1:0]   gnt_code_q;
    logic [CODE_W-1:0]   g2_q;
    logic                gnt_valid_q;
    logic                enc_err_q;

    logic                hs;
    logic [N-1:0]        clr;
    logic                first_bad;
    logic                second_bad;
    logic [CODE_W-1:0]   first_eff;
    logic [CODE_W-1:0]   second_eff;

    assign hs = gnt_valid_q & gnt_ready;

    // Decode the accepted grant into the pending bit it serves.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_clr
            assign clr[gi] = hs && (gnt_code_q == CODE_W'(gi + 1));
        end
    endgenerate

    // Out-of-range encoder codes are treated as "no request".
    assign first_bad  = (first  > N_CODE);
    assign second_bad = (second > N_CODE);
    assign first_eff  = first_bad  ? '0 : first;
    assign second_eff = second_bad ? '0 : second;

    // Next pending set: a same-cycle request wins over the grant clear; flush drops
    // everything except this cycle's requests and ignores any handshake.
    always_comb begin
        pend_d = (pend_q & ~clr) | req_in;
        if (flush) begin
            pend_d = req_in;
        end
    end

    // Pending request register, feeds the encoder directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Grant sequencer: decide in IDLE from the encoder, hold each grant until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_code_q  <= '0;
            g2_q        <= '0;
            gnt_valid_q <= 1'b0;
            enc_err_q   <= 1'b0;
        end else begin
            enc_err_q <= 1'b0;
            if (flush) begin
                state_q     <= IDLE;
                gnt_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        enc_err_q <= first_bad | second_bad;
                        if (first_eff != '0) begin
                            gnt_code_q  <= first_eff;
                            g2_q        <= second_eff;
                            gnt_valid_q <= 1'b1;
                            state_q     <= GRANT1;
                        end
                    end
                    GRANT1: begin
                        if (hs) begin
                            if (PAIR_EN && (g2_q != '0)) begin
                                // g2's pend bit is still set: only grants clear pend.
                                gnt_code_q <= g2_q;
                                state_q    <= GRANT2;
                            end else begin
                                gnt_valid_q <= 1'b0;
                                state_q     <= IDLE;
                            end
                        end
                    end
                    GRANT2: begin
                        if (hs) begin
                            gnt_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                    default: begin
                        gnt_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                endcase
            end
        end
    end

    assign pend      = pend_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_code  = gnt_code_q;
    assign enc_err   = enc_err_q;
    assign busy      = (state_q != IDLE);

endmodule
